// File: rtl/round_pack_pkg.sv
// Shared constants for the soft-float round-and-pack stage: exception flags, rounding modes and
// the one-hot FSM state encoding.
package round_pack_pkg;

    localparam logic [31:0] FLAG_NX = 32'h0000_0001;
    localparam logic [31:0] FLAG_UF = 32'h0000_0004;
    localparam logic [31:0] FLAG_OF = 32'h0000_0008;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_DN  = 2'd2;
    localparam logic [1:0] RM_UP  = 2'd3;

    typedef enum logic [3:0] {
        StCap   = 4'b0001,
        StShift = 4'b0010,
        StRound = 4'b0100,
        StPack  = 4'b1000
    } state_t;

endpackage

// File: rtl/shift_right_jam.sv
// Combinational right shift that ORs every shifted-out bit into the result LSB (sticky jam);
// counts of W or more collapse the whole operand into that sticky bit.
module shift_right_jam #(
    parameter int unsigned W  = 64,
    parameter int unsigned CW = 13
) (
    input  logic [W-1:0]  a,
    input  logic [CW-1:0] count,
    output logic [W-1:0]  y
);

    logic [W-1:0] lost_mask;

    always_comb begin
        lost_mask = ~({W{1'b1}} << count);
        if (32'(count) >= W) begin
            y = {{(W-1){1'b0}}, |a};
        end else begin
            y = (a >> count) | {{(W-1){1'b0}}, |(a & lost_mask)};
        end
    end

endmodule

// File: rtl/round_pack_float_param.sv
// Round-and-pack stage: rounds an unrounded significand and packs a 1+EXP_W+FRAC_W float word.
// Define ROUND_PACK_DENORM_EN to produce subnormals; otherwise tiny results flush to signed zero.
module round_pack_float_param
    import round_pack_pkg::*;
#(
    parameter int unsigned EXP_W  = 11,
    parameter int unsigned FRAC_W = 52,
    parameter int unsigned SIG_W  = 64
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    output logic                    ap_ready,
    input  logic                    z_sign,
    input  logic [EXP_W+1:0]        z_exp,
    input  logic [SIG_W-1:0]        z_sig,
    input  logic [1:0]              rnd_mode,
    input  logic [31:0]             flag_i,
    output logic [31:0]             flag_o,
    output logic                    flag_o_ap_vld,
    output logic [EXP_W+FRAC_W:0]   ap_return
);

    localparam int unsigned ROUND_W = SIG_W - FRAC_W - 2;
    localparam int unsigned RSIG_W  = SIG_W + 1 - ROUND_W;
    localparam int unsigned PACK_W  = 1 + EXP_W + FRAC_W;
    localparam int unsigned CNT_W   = EXP_W + 2;

    localparam logic [CNT_W-1:0]   OVF_LIM  = CNT_W'((1 << EXP_W) - 3);
    localparam logic [ROUND_W-1:0] RB_HALF  = ROUND_W'(1) << (ROUND_W - 1);
    localparam logic [PACK_W-2:0]  INF_BODY = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    localparam logic [PACK_W-2:0]  MAX_BODY = INF_BODY - (PACK_W - 1)'(1);

    function automatic logic [ROUND_W-1:0] round_inc(input logic [1:0] mode, input logic sign);
        logic [ROUND_W-1:0] inc;
        unique case (mode)
            RM_RNE:  inc = RB_HALF;
            RM_RTZ:  inc = '0;
            RM_DN:   inc = sign ? '1 : '0;
            default: inc = sign ? '0 : '1;
        endcase
        return inc;
    endfunction

    state_t              state_q;
    logic                sign_q;
    logic [EXP_W-1:0]    exp_q;
    logic [SIG_W-1:0]    sig_q;
    logic [1:0]          mode_q;
    logic [ROUND_W-1:0]  inc_q;
    logic                ovf_q;
    logic                tiny_q;
    logic                uf_q;
    logic [CNT_W-1:0]    shamt_q;
    logic                done_q;
    logic                vld_q;
    logic [31:0]         flags_q;
    logic [PACK_W-1:0]   ret_q;

    // Capture-time classification.
    logic [ROUND_W-1:0]  cap_inc;
    logic                cap_tiny;
    logic                cap_carry;
    logic                cap_ovf;
    logic [CNT_W-1:0]    cap_shamt;

    always_comb begin
        cap_inc   = round_inc(rnd_mode, z_sign);
        cap_tiny  = z_exp[EXP_W+1];
        cap_carry = |(({1'b0, z_sig} + {{RSIG_W{1'b0}}, cap_inc}) >> (SIG_W - 1));
        // Negative exponents look huge unsigned, so tiny must win over overflow.
        cap_ovf   = !cap_tiny && ((z_exp > OVF_LIM) || ((z_exp == OVF_LIM) && cap_carry));
`ifdef ROUND_PACK_DENORM_EN
        cap_shamt = cap_tiny ? -z_exp : '0;
`else
        cap_shamt = '0;
`endif
    end

    logic [SIG_W-1:0] sig_jam;
    logic             shift_uf;

    shift_right_jam #(
        .W  (SIG_W),
        .CW (CNT_W)
    ) u_jam (
        .a     (sig_q),
        .count (shamt_q),
        .y     (sig_jam)
    );

`ifdef ROUND_PACK_DENORM_EN
    assign shift_uf = tiny_q && (sig_jam[ROUND_W-1:0] != '0);
`else
    assign shift_uf = tiny_q;
`endif

    // Rounding and packing of the (possibly denormalised) significand.
    logic [ROUND_W-1:0] rb;
    logic [RSIG_W-1:0]  rsig;
    logic [EXP_W-1:0]   rexp;
    logic [PACK_W-1:0]  packed_word;
    logic               ovf_inf;
    logic [PACK_W-1:0]  res;
    logic [31:0]        new_flags;

    always_comb begin
        rb   = sig_q[ROUND_W-1:0];
        rsig = RSIG_W'(({1'b0, sig_q} + {{RSIG_W{1'b0}}, inc_q}) >> ROUND_W);
        if ((mode_q == RM_RNE) && (rb == RB_HALF)) begin
            rsig[0] = 1'b0;
        end
        rexp = (rsig == '0) ? '0 : exp_q;
        // Hidden bit lands on the exponent LSB, so a rounding carry bumps the exponent.
        packed_word = {sign_q, {(PACK_W-1){1'b0}}} + (PACK_W'(rexp) << FRAC_W) + PACK_W'(rsig);
        ovf_inf = (mode_q == RM_RNE) || ((mode_q == RM_UP) && !sign_q) ||
                  ((mode_q == RM_DN) && sign_q);

        res       = packed_word;
        new_flags = '0;
        if (rb != '0) begin
            new_flags = FLAG_NX;
        end
        if (uf_q) begin
            new_flags = new_flags | FLAG_UF;
        end
        if (ovf_q) begin
            res       = {sign_q, ovf_inf ? INF_BODY : MAX_BODY};
            new_flags = FLAG_OF | FLAG_NX;
        end
`ifndef ROUND_PACK_DENORM_EN
        else if (tiny_q) begin
            res       = {sign_q, {(PACK_W-1){1'b0}}};
            new_flags = FLAG_UF | FLAG_NX;
        end
`endif
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= StCap;
            ret_q   <= '0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            unique case (state_q)
                StCap: begin
                    if (ap_start) begin
                        sign_q  <= z_sign;
                        exp_q   <= z_exp[EXP_W-1:0];
                        sig_q   <= z_sig;
                        mode_q  <= rnd_mode;
                        inc_q   <= cap_inc;
                        ovf_q   <= cap_ovf;
                        tiny_q  <= cap_tiny;
                        shamt_q <= cap_shamt;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    sig_q <= sig_jam;
                    uf_q  <= shift_uf;
                    if (tiny_q) begin
                        exp_q <= '0;
                    end
                    state_q <= StRound;
                end
                StRound: begin
                    ret_q   <= res;
                    flags_q <= new_flags;
                    vld_q   <= (new_flags != '0);
                    done_q  <= 1'b1;
                    state_q <= StPack;
                end
                StPack: begin
                    done_q  <= 1'b0;
                    vld_q   <= 1'b0;
                    flags_q <= '0;
                    state_q <= StCap;
                end
                default: begin
                    state_q <= StCap;
                end
            endcase
        end
    end

    assign ap_done       = done_q;
    assign ap_ready      = done_q;
    assign ap_idle       = (state_q == StCap) && !ap_start;
    assign flag_o        = flag_i | flags_q;
    assign flag_o_ap_vld = vld_q;
    assign ap_return     = ret_q;

endmodule

// File: tb/tb_round_pack_float_param.sv
// Scoreboard bench for round_pack_float_param at default widths; expectations follow
// ROUND_PACK_DENORM_EN when it is defined.
module tb_round_pack_float_param;

    logic        clk;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic        z_sign;
    logic [12:0] z_exp;
    logic [63:0] z_sig;
    logic [1:0]  rnd_mode;
    logic [31:0] flag_i;
    logic [31:0] flag_o;
    logic        flag_o_ap_vld;
    logic [63:0] ap_return;

    round_pack_float_param #(
        .EXP_W  (11),
        .FRAC_W (52),
        .SIG_W  (64)
    ) dut (
        .ap_clk        (clk),
        .ap_rst        (ap_rst),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .z_sign        (z_sign),
        .z_exp         (z_exp),
        .z_sig         (z_sig),
        .rnd_mode      (rnd_mode),
        .flag_i        (flag_i),
        .flag_o        (flag_o),
        .flag_o_ap_vld (flag_o_ap_vld),
        .ap_return     (ap_return)
    );

    typedef struct {
        logic        sign;
        logic [12:0] exp;
        logic [63:0] sig;
        logic [1:0]  rm;
        logic [63:0] ret;
        logic [31:0] nf;
    } op_t;

    typedef struct {
        int          id;
        int          c0;
        logic [63:0] ret;
        logic [31:0] flg;
        logic        vld;
    } exp_t;

    op_t  ops[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic add_op(input logic sign, input logic [12:0] exp, input logic [63:0] sig,
                          input logic [1:0] rm, input logic [63:0] ret, input logic [31:0] nf);
        op_t o;
        o.sign = sign; o.exp = exp; o.sig = sig; o.rm = rm; o.ret = ret; o.nf = nf;
        ops.push_back(o);
    endtask

    task automatic issue(input int idx, input bit hold);
        exp_t e;
        @(posedge clk);
        #2;
        z_sign   = ops[idx].sign;
        z_exp    = ops[idx].exp;
        z_sig    = ops[idx].sig;
        rnd_mode = ops[idx].rm;
        ap_start = 1'b1;
        e.id  = idx;
        e.c0  = cyc;
        e.ret = ops[idx].ret;
        e.flg = flag_i | ops[idx].nf;
        e.vld = (ops[idx].nf != 0);
        sb.push_back(e);
        @(posedge clk);
        #2;
        // Scramble inputs so a DUT that fails to capture them is exposed.
        ap_start = hold;
        z_sign   = 1'($urandom);
        z_exp    = 13'($urandom);
        z_sig    = {$urandom, $urandom};
        rnd_mode = 2'($urandom);
        @(posedge clk);
        @(posedge clk);
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (ap_done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", 64'(ap_done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq($sformatf("op%0d ret", e.id), ap_return, e.ret);
                    check_eq($sformatf("op%0d flag_o", e.id), 64'(flag_o), 64'(e.flg));
                    check_eq($sformatf("op%0d vld", e.id), 64'(flag_o_ap_vld), 64'(e.vld));
                    check_eq($sformatf("op%0d ready", e.id), 64'(ap_ready), 64'd1);
                    check_eq($sformatf("op%0d latency", e.id), 64'(cyc - e.c0), 64'd4);
                end
            end
        end
    end

    initial begin
        int d0;
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        z_sign   = 1'b0;
        z_exp    = '0;
        z_sig    = '0;
        rnd_mode = 2'd0;
        flag_i   = 32'h0000_0100;

        add_op(1'b0, 13'h3FE, 64'h4000_0000_0000_0000, 2'd0, 64'h3FF0_0000_0000_0000, 32'h0);
        add_op(1'b0, 13'h3FE, 64'h4000_0000_0000_0200, 2'd0, 64'h3FF0_0000_0000_0000, 32'h1);
        add_op(1'b0, 13'h3FE, 64'h4000_0000_0000_0200, 2'd3, 64'h3FF0_0000_0000_0001, 32'h1);
`ifdef ROUND_PACK_DENORM_EN
        add_op(1'b0, 13'h1FFF, 64'h4000_0000_0000_0000, 2'd0, 64'h0008_0000_0000_0000, 32'h0);
        add_op(1'b0, 13'h1F9C, 64'h4000_0000_0000_0000, 2'd3, 64'h0000_0000_0000_0001, 32'h5);
`else
        add_op(1'b0, 13'h1FFF, 64'h4000_0000_0000_0000, 2'd0, 64'h0000_0000_0000_0000, 32'h5);
        add_op(1'b0, 13'h1F9C, 64'h4000_0000_0000_0000, 2'd3, 64'h0000_0000_0000_0000, 32'h5);
`endif
        add_op(1'b1, 13'h3FE, 64'h4000_0000_0000_0001, 2'd2, 64'hBFF0_0000_0000_0001, 32'h1);
        add_op(1'b0, 13'h7FD, 64'h7FFF_FFFF_FFFF_FE00, 2'd0, 64'h7FF0_0000_0000_0000, 32'h9);
        add_op(1'b0, 13'h7FD, 64'h7FFF_FFFF_FFFF_FE00, 2'd1, 64'h7FEF_FFFF_FFFF_FFFF, 32'h1);
        add_op(1'b1, 13'h7FE, 64'h4000_0000_0000_0000, 2'd1, 64'hFFEF_FFFF_FFFF_FFFF, 32'h9);
        add_op(1'b1, 13'h7FE, 64'h4000_0000_0000_0000, 2'd2, 64'hFFF0_0000_0000_0000, 32'h9);
        add_op(1'b0, 13'h3FE, 64'h7FFF_FFFF_FFFF_FE00, 2'd0, 64'h4000_0000_0000_0000, 32'h1);
        add_op(1'b0, 13'h3FE, 64'h4000_0000_0000_0600, 2'd0, 64'h3FF0_0000_0000_0002, 32'h1);
        add_op(1'b1, 13'h3FE, 64'h0000_0000_0000_0000, 2'd0, 64'h8000_0000_0000_0000, 32'h0);
        add_op(1'b0, 13'h3FE, 64'h4000_0000_0000_0200, 2'd1, 64'h3FF0_0000_0000_0000, 32'h1);

        repeat (2) @(posedge clk);
        #2;
        ap_rst = 1'b0;
        check_eq("reset ret", ap_return, 64'd0);
        check_eq("reset done", 64'(ap_done), 64'd0);
        check_eq("reset ready", 64'(ap_ready), 64'd0);
        check_eq("reset vld", 64'(flag_o_ap_vld), 64'd0);
        check_eq("reset idle", 64'(ap_idle), 64'd1);
        check_eq("reset flag_o", 64'(flag_o), 64'(flag_i));

        // Isolated operations with idle gaps.
        for (int i = 0; i < 6; i++) begin
            issue(i, 1'b0);
            repeat (2) @(posedge clk);
        end
        // Back-to-back with ap_start held high.
        for (int i = 6; i < ops.size(); i++) begin
            issue(i, i != ops.size() - 1);
        end

        repeat (8) @(posedge clk);
        check_eq("sb drained", 64'(sb.size()), 64'd0);
        check_eq("done count", 64'(done_cnt), 64'(ops.size()));

        // Abort an operation with reset while it sits in the rounding state.
        @(posedge clk);
        #2;
        z_sign   = ops[0].sign;
        z_exp    = ops[0].exp;
        z_sig    = ops[0].sig;
        rnd_mode = ops[0].rm;
        ap_start = 1'b1;
        @(posedge clk);
        #2;
        ap_start = 1'b0;
        @(posedge clk);
        #2;
        ap_rst = 1'b1;
        @(posedge clk);
        #2;
        ap_rst = 1'b0;
        check_eq("abort idle", 64'(ap_idle), 64'd1);
        check_eq("abort ret", ap_return, 64'd0);
        check_eq("abort done", 64'(ap_done), 64'd0);
        d0 = done_cnt;
        repeat (6) @(posedge clk);
        check_eq("abort no done", 64'(done_cnt), 64'(d0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
